// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: a start_n falling edge loads a word, which is sent one bit per DIV clocks.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_n,
    input  logic [WIDTH-1:0] data,
    input  logic             msb_first,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shreg
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    logic par_r;
`endif

    logic [1:0]       state_r;
    logic             s_r;
    logic             s_rp;
    logic             dir_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             start_evt_s;

    assign start_evt_s = ~s_r & s_rp;

    // Two-flop button sampler; reset to released so no event fires when reset drops
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r  <= 1'b1;
            s_rp <= 1'b1;
        end else begin
            s_r  <= start_n;
            s_rp <= s_r;
        end
    end

    // Transfer FSM: load, bit timing, shifting and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shreg     <= '0;
            sout      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir_r     <= 1'b0;
            bit_cnt_r <= '0;
            div_cnt_r <= '0;
`ifdef PISO_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    sout <= 1'b1;
                    busy <= 1'b0;
                    if (start_evt_s) begin
                        shreg     <= data;
                        dir_r     <= msb_first;
                        bit_cnt_r <= '0;
                        div_cnt_r <= '0;
                        busy      <= 1'b1;
                        sout      <= msb_first ? data[WIDTH-1] : data[0];
`ifdef PISO_PARITY_EN
                        par_r     <= even_parity(data);
`endif
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
`ifdef PISO_PARITY_EN
                            state_r <= PARITY;
                            sout    <= par_r;
`else
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            sout    <= 1'b1;
                            done    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            // Next bit to drive is the one adjacent to the output end
                            if (dir_r) begin
                                shreg <= {shreg[WIDTH-2:0], 1'b0};
                                sout  <= shreg[WIDTH-2];
                            end else begin
                                shreg <= {1'b0, shreg[WIDTH-1:1]};
                                sout  <= shreg[1];
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                        sout      <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    sout    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out shift register. It is the transmit-side counterpart of the board's serial-in LED shift register.
- A button press loads a WIDTH-bit word from the switches.
- The word is shifted out one bit per DIV clock cycles on a single serial line.
- Transfer status is exposed on busy/done, and the live register contents drive the LEDs.

Parameters:
WIDTH, 8, word length in bits (>=2)
DIV, 50000000, clock cycles each bit is held on sout (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start_n  input  1  raw active-low button level; its falling edge starts a transfer
data  input  WIDTH  parallel word (switches); sampled only at load
msb_first  input  1  1: shift MSB first; 0: shift LSB first; sampled only at load
sout  output  1  serial output, registered
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when the last bit period ends
shreg  output  WIDTH  current shift register contents (LED view)

Behaviour:
- Start detection:
  - start_n goes through two flops (s_r, then s_rp).
  - start_evt = ~s_r & s_rp.
  - The load happens on the clock edge after the edge that first samples start_n low.
- States: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- Reset (rst=1 at a clk edge):
  - state=IDLE, shreg=0, sout=1, busy=0, done=0.
  - s_r=s_rp=1, so no spurious event when reset releases.
  - Bit counter and divider counter = 0.
  - This applies mid-transfer too: the transfer aborts immediately and no done pulse is produced.
- IDLE:
  - sout=1, busy=0.
  - On start_evt: shreg<=data, dir<=msb_first, bit_cnt<=0, div_cnt<=0, busy<=1, sout<=first bit, go to SHIFT.
  - First bit is data[WIDTH-1] if msb_first, else data[0].
- SHIFT:
  - div_cnt counts 0..DIV-1. Each bit is held exactly DIV cycles.
  - When div_cnt==DIV-1 and bit_cnt<WIDTH-1:
    - div_cnt<=0, bit_cnt<=bit_cnt+1.
    - shreg shifts toward the output end with zero fill: left if dir=1, right if dir=0.
    - sout<=the next bit.
  - When div_cnt==DIV-1 and bit_cnt==WIDTH-1:
    - state<=IDLE, busy<=0, sout<=1, done<=1 for exactly one cycle.
    - shreg holds its last shifted value.
- Totals: busy is high for exactly WIDTH*DIV cycles. done goes high in the first cycle busy is low.
- start_evt while busy is ignored and not queued. Changes on data and msb_first while busy are ignored.
- Counter widths: bit_cnt is $clog2(WIDTH+1) bits; div_cnt is $clog2(DIV) bits, minimum 1. With DIV=1 each bit lasts one cycle.
- A start_evt in the same cycle that done is asserted is accepted: the block is IDLE then, so back-to-back transfers are allowed.

Optional Feature:
Macro: PISO_PARITY_EN
- Defined:
  - After the last data bit period the FSM enters PARITY instead of IDLE.
  - sout = even parity (XOR) of the word latched at load, held DIV cycles.
  - Then IDLE with the done pulse.
  - busy lasts (WIDTH+1)*DIV cycles.
- Undefined: no PARITY state; timing exactly as in Behaviour.

Test Plan:
- Reset: WIDTH=8, DIV=4; hold rst 2 cycles -> sout=1, busy=0, done=0, shreg=8'h00; start_n held high gives no activity for 50 cycles.
- MSB-first: data=8'hA5, msb_first=1, pulse start_n low 3 cycles -> sout=1,0,1,0,0,1,0,1, each for 4 cycles; busy high 32 cycles; done pulses once; sout returns to 1.
- LSB-first: data=8'h0F, msb_first=0 -> sout=1,1,1,1,0,0,0,0, 4 cycles each; shreg after the first shift =8'h07.
- Ignore while busy: during the h0F transfer, pulse start_n again and change data to 8'hFF -> output sequence unchanged; exactly one done pulse; no second transfer.
- Abort: assert rst during bit 3 of the hA5 transfer -> next cycle busy=0, sout=1, shreg=0, no done pulse; a fresh start afterwards transmits the full hA5 correctly.
- Parity (PISO_PARITY_EN): data=8'h07, msb_first=1 -> 8 data bits then a 9th bit of 1 for 4 cycles; busy high 36 cycles. data=8'h03 -> 9th bit 0.
